// File: rtl/word_byte_streamer_if.sv
// Bus bundle for word_byte_streamer: word write port, read request, byte stream out.
// rd_burst exists only when WORD_BYTE_STREAMER_BURST_EN is defined.
interface word_byte_streamer_if;
  logic        wr_valid;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rd_valid;
  logic [5:0]  rd_addr;
`ifdef WORD_BYTE_STREAMER_BURST_EN
  logic        rd_burst;
`endif
  logic        busy;
  logic        out_valid;
  logic [7:0]  out_data;

  modport master (
    output wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
`ifdef WORD_BYTE_STREAMER_BURST_EN
    output rd_burst,
`endif
    input  busy, out_valid, out_data
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
`ifdef WORD_BYTE_STREAMER_BURST_EN
    input  rd_burst,
`endif
    output busy, out_valid, out_data
  );
endinterface

// File: rtl/word_byte_streamer.sv
// 64x32 word store streamed out LSB-byte first, 4 bytes per read (16 in burst).
// Optional burst reads enabled by defining WORD_BYTE_STREAMER_BURST_EN.
module word_byte_streamer (
  input  logic clk,
  input  logic rst_n,
  word_byte_streamer_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t      state_reg, state_next;
  logic [31:0] shift_reg, shift_next;
  logic [1:0]  byte_cnt_reg, byte_cnt_next;
  logic [1:0]  word_cnt_reg, word_cnt_next;
  logic [5:0]  addr_reg, addr_next;
  logic [5:0]  addr_inc;
  logic        burst_req;
  logic [31:0] mem_reg [64];

`ifdef WORD_BYTE_STREAMER_BURST_EN
  assign burst_req = bus.rd_burst;
`else
  assign burst_req = 1'b0;
`endif

  assign addr_inc = addr_reg + 6'd1;

  // Storage must clear on reset, so it is a register array rather than a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (bus.wr_valid) begin
      mem_reg[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      byte_cnt_reg <= '0;
      word_cnt_reg <= '0;
      addr_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      byte_cnt_reg <= byte_cnt_next;
      word_cnt_reg <= word_cnt_next;
      addr_reg     <= addr_next;
    end
  end

  // Latches read mem_reg before the same-edge write lands, giving read-before-write.
  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    byte_cnt_next = byte_cnt_reg;
    word_cnt_next = word_cnt_reg;
    addr_next     = addr_reg;
    case (state_reg)
      IDLE: begin
        if (bus.rd_valid) begin
          state_next    = SEND;
          shift_next    = mem_reg[bus.rd_addr];
          byte_cnt_next = 2'd0;
          addr_next     = bus.rd_addr;
          word_cnt_next = burst_req ? 2'd3 : 2'd0;
        end
      end
      SEND: begin
        byte_cnt_next = byte_cnt_reg + 2'd1;
        shift_next    = {8'h00, shift_reg[31:8]};
        if (byte_cnt_reg == 2'd3) begin
          if (word_cnt_reg != 2'd0) begin
            shift_next    = mem_reg[addr_inc];
            addr_next     = addr_inc;
            word_cnt_next = word_cnt_reg - 2'd1;
          end else begin
            state_next = IDLE;
            shift_next = '0;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.busy      = (state_reg == SEND);
  assign bus.out_valid = (state_reg == SEND);
  assign bus.out_data  = (state_reg == SEND) ? shift_reg[7:0] : 8'h00;

endmodule

// File: tb/tb_word_byte_streamer.sv
// Self-checking bench for word_byte_streamer: table of write/read vectors plus
// hand sequences; expected bytes are queued at stimulus and popped by a monitor.
module tb_word_byte_streamer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  word_byte_streamer_if bus_if ();

  word_byte_streamer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
    logic [7:0]  exp_b [4];
  } vec_t;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_bytes(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
    exp_q.push_back(b0);
    exp_q.push_back(b1);
    exp_q.push_back(b2);
    exp_q.push_back(b3);
  endtask

  // Monitor: samples on the falling edge, pops one expected byte per valid cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_if.out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_byte: got %h, expected no output at %0t", bus_if.out_data, $time);
        end else begin
          check("stream_byte", 32'(bus_if.out_data), 32'(exp_q.pop_front()));
        end
      end else begin
        check("idle_out_data", 32'(bus_if.out_data), 32'h0);
      end
      check("busy_eq_out_valid", 32'(bus_if.busy), 32'(bus_if.out_valid));
    end
  end

  task automatic write_word(input logic [5:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_if.wr_valid = 1'b1;
    bus_if.wr_addr  = a;
    bus_if.wr_data  = d;
    @(negedge clk);
    bus_if.wr_valid = 1'b0;
  endtask

  // Issues a read; optionally a same-cycle write to the same word, and a
  // spurious request on the cycle after acceptance. Checks stream length.
  task automatic do_read(input logic [5:0] a, input bit burst, input int nbytes,
                         input bit wr_same, input logic [31:0] wd, input bit spur);
    @(negedge clk);
    bus_if.rd_valid = 1'b1;
    bus_if.rd_addr  = a;
`ifdef WORD_BYTE_STREAMER_BURST_EN
    bus_if.rd_burst = burst;
`else
    if (burst) $display("note: burst requested but not built");
`endif
    bus_if.wr_valid = wr_same;
    bus_if.wr_addr  = a;
    bus_if.wr_data  = wd;
    @(negedge clk);
    bus_if.wr_valid = 1'b0;
    bus_if.rd_valid = spur;
    bus_if.rd_addr  = 6'd3;
`ifdef WORD_BYTE_STREAMER_BURST_EN
    bus_if.rd_burst = 1'b0;
`endif
    check("first_byte_latency", 32'(bus_if.out_valid), 32'h1);
    for (int k = 1; k < nbytes; k++) begin
      @(negedge clk);
      bus_if.rd_valid = 1'b0;
      check("stream_valid", 32'(bus_if.out_valid), 32'h1);
    end
    @(negedge clk);
    check("stream_end_valid", 32'(bus_if.out_valid), 32'h0);
    check("stream_end_data", 32'(bus_if.out_data), 32'h0);
  endtask

  vec_t tbl [5];

  initial begin
    tbl[0] = '{addr: 6'd9,  data: 32'hA1B2C3D4, exp_b: '{8'hD4, 8'hC3, 8'hB2, 8'hA1}};
    tbl[1] = '{addr: 6'd63, data: 32'hDEADBEEF, exp_b: '{8'hEF, 8'hBE, 8'hAD, 8'hDE}};
    tbl[2] = '{addr: 6'd0,  data: 32'h01020304, exp_b: '{8'h04, 8'h03, 8'h02, 8'h01}};
    tbl[3] = '{addr: 6'd33, data: 32'h80000001, exp_b: '{8'h01, 8'h00, 8'h00, 8'h80}};
    tbl[4] = '{addr: 6'd17, data: 32'hFFFFFFFF, exp_b: '{8'hFF, 8'hFF, 8'hFF, 8'hFF}};

    bus_if.wr_valid = 1'b0;
    bus_if.wr_addr  = '0;
    bus_if.wr_data  = '0;
    bus_if.rd_valid = 1'b0;
    bus_if.rd_addr  = '0;
`ifdef WORD_BYTE_STREAMER_BURST_EN
    bus_if.rd_burst = 1'b0;
`endif

    #1;
    check("reset_busy", 32'(bus_if.busy), 32'h0);
    check("reset_out_valid", 32'(bus_if.out_valid), 32'h0);
    check("reset_out_data", 32'(bus_if.out_data), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Fresh memory reads as zero.
    push_bytes(8'h00, 8'h00, 8'h00, 8'h00);
    do_read(6'd5, 1'b0, 4, 1'b0, 32'h0, 1'b0);

    for (int i = 0; i < 5; i++) begin
      write_word(tbl[i].addr, tbl[i].data);
      push_bytes(tbl[i].exp_b[0], tbl[i].exp_b[1], tbl[i].exp_b[2], tbl[i].exp_b[3]);
      do_read(tbl[i].addr, 1'b0, 4, 1'b0, 32'h0, 1'b0);
    end

    // Request during a stream is dropped; addr 3 holds distinct data to expose it.
    write_word(6'd3, 32'h55667788);
    push_bytes(8'hD4, 8'hC3, 8'hB2, 8'hA1);
    do_read(6'd9, 1'b0, 4, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    check("no_queued_read", 32'(bus_if.out_valid), 32'h0);

    // Same-cycle write to the word being latched: old value out, new value next time.
    write_word(6'd7, 32'hFFFFFFFF);
    push_bytes(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    do_read(6'd7, 1'b0, 4, 1'b1, 32'h11223344, 1'b0);
    push_bytes(8'h44, 8'h33, 8'h22, 8'h11);
    do_read(6'd7, 1'b0, 4, 1'b0, 32'h0, 1'b0);

`ifdef WORD_BYTE_STREAMER_BURST_EN
    write_word(6'd62, 32'h00000001);
    write_word(6'd63, 32'h00000002);
    write_word(6'd0,  32'h00000003);
    write_word(6'd1,  32'h00000004);
    push_bytes(8'h01, 8'h00, 8'h00, 8'h00);
    push_bytes(8'h02, 8'h00, 8'h00, 8'h00);
    push_bytes(8'h03, 8'h00, 8'h00, 8'h00);
    push_bytes(8'h04, 8'h00, 8'h00, 8'h00);
    do_read(6'd62, 1'b1, 16, 1'b0, 32'h0, 1'b0);
`endif

    // Asynchronous reset in the middle of the second byte.
    push_bytes(8'hD4, 8'hC3, 8'h00, 8'h00);
    @(negedge clk);
    bus_if.rd_valid = 1'b1;
    bus_if.rd_addr  = 6'd9;
    @(negedge clk);
    bus_if.rd_valid = 1'b0;
    check("pre_reset_valid", 32'(bus_if.out_valid), 32'h1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_valid", 32'(bus_if.out_valid), 32'h0);
    check("async_reset_data", 32'(bus_if.out_data), 32'h0);
    check("async_reset_busy", 32'(bus_if.busy), 32'h0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_reset_idle", 32'(bus_if.out_valid), 32'h0);

    push_bytes(8'h00, 8'h00, 8'h00, 8'h00);
    do_read(6'd9, 1'b0, 4, 1'b0, 32'h0, 1'b0);
    push_bytes(8'h00, 8'h00, 8'h00, 8'h00);
    do_read(6'd7, 1'b0, 4, 1'b0, 32'h0, 1'b0);

    repeat (4) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

endmodule
